// File: rtl/axis_fifo_write_arbiter.sv
// Round-robin, packet-granular arbiter that shares one AXI-stream FIFO write port among N sources.
// It can insert a source-id header beat before each packet and gates each new grant on the FIFO's free space.
module axis_fifo_write_arbiter #(
    parameter int unsigned N          = 4,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_BITS = 7,
    parameter int unsigned MIN_FREE   = 16,
    parameter int unsigned HEADER     = 1,
    parameter int unsigned MAX_BEATS  = 256,
    localparam int unsigned IDW       = $clog2(N)
) (
    input  logic                  rst,
    input  logic                  s_clk,
    input  logic [N-1:0]          req_valid,
    output logic [N-1:0]          req_ready,
    input  logic [N*WIDTH-1:0]    req_data,
    input  logic [N-1:0]          req_last,
    output logic                  fifo_valid,
    input  logic                  fifo_ready,
    output logic [WIDTH-1:0]      fifo_data,
    input  logic [DEPTH_BITS-1:0] fifo_load,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy,
    output logic                  trunc_err
);

    localparam int unsigned CW = $clog2(MAX_BEATS + 1);
    localparam int unsigned FW = DEPTH_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           trunc_q, trunc_d;

    logic [FW-1:0]  free_c;
    logic           space_ok;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic [IDW-1:0] cand;
    int unsigned    g_base;

    // Free entries in the FIFO; only consulted when a new packet would start.
    assign free_c   = FW'((1 << DEPTH_BITS) - 1) - {1'b0, fifo_load};
    assign space_ok = (free_c >= FW'(MIN_FREE));

    // First valid source scanning upward from the one after the last grant.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = grant_q;
        cand       = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDW'((32'(grant_q) + k) % N);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge s_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= IDW'(N - 1);
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    // Next state plus the write-port mux; DATA is a direct path from the granted source.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        trunc_d    = 1'b0;
        fifo_valid = 1'b0;
        fifo_data  = '0;
        req_ready  = '0;
        g_base     = 32'(grant_q) * WIDTH;

        case (state_q)
            ST_IDLE: begin
                if (pick_found && space_ok) begin
                    grant_d = pick_idx;
                    state_d = (HEADER != 0) ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                fifo_valid = 1'b1;
                fifo_data  = WIDTH'(grant_q);
                if (fifo_ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                fifo_valid         = req_valid[grant_q];
                fifo_data          = req_data[g_base +: WIDTH];
                req_ready[grant_q] = fifo_ready;
                if (req_valid[grant_q] && fifo_ready) begin
                    if (req_last[grant_q]) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else if (cnt_q == CW'(MAX_BEATS - 1)) begin
                        // Runaway packet: cut it so other sources are not locked out.
                        cnt_d   = '0;
                        trunc_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign trunc_err = trunc_q;

endmodule

// File: tb/tb_axis_fifo_write_arbiter.sv
// Directed bench for axis_fifo_write_arbiter: queued per-source packets, captured FIFO beats vs hand-built lists.
module tb_axis_fifo_write_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned DB = 7;

    logic            rst;
    logic            s_clk;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_last;
    logic            fifo_valid;
    logic            fifo_ready;
    logic [W-1:0]    fifo_data;
    logic [DB-1:0]   fifo_load;
    logic [1:0]      grant_id;
    logic            busy;
    logic            trunc_err;

    axis_fifo_write_arbiter #(
        .N(N), .WIDTH(W), .DEPTH_BITS(DB), .MIN_FREE(16), .HEADER(1), .MAX_BEATS(4)
    ) dut (
        .rst(rst), .s_clk(s_clk),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
        .fifo_valid(fifo_valid), .fifo_ready(fifo_ready), .fifo_data(fifo_data), .fifo_load(fifo_load),
        .grant_id(grant_id), .busy(busy), .trunc_err(trunc_err)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    // Source queues hold {last, data}; next-cycle input values are staged in nx_*.
    logic [8:0]  srcq [N][$];
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];
    logic [N-1:0] acc;
    logic        nx_rst, nx_ready;
    logic [DB-1:0] nx_load;
    int          n_chk, n_bad;
    int          trunc_cnt, trunc_at, rr_bad, acc3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ex(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp_q[i]));
        exp_q.delete();
        got.delete();
    endtask

    task automatic tick();
        logic [8:0] e;
        logic [N-1:0] gmask;
        @(posedge s_clk);
        #1;
        rst        = nx_rst;
        fifo_ready = nx_ready;
        fifo_load  = nx_load;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) srcq[i].delete(0);
            e = (srcq[i].size() > 0) ? srcq[i][0] : 9'h0;
            req_valid[i]       = (srcq[i].size() > 0);
            req_last[i]        = e[8];
            req_data[i*W +: W] = e[7:0];
        end
        @(negedge s_clk);
        acc = req_valid & req_ready;
        if (fifo_valid && fifo_ready) got.push_back(fifo_data);
        if (trunc_err) begin
            trunc_cnt++;
            trunc_at = got.size();
        end
        gmask = fifo_ready ? (N'(1) << grant_id) : '0;
        if ((req_ready & ~gmask) != '0) rr_bad++;
        if (acc[3]) acc3++;
    endtask

    task automatic run_until(input int n, input int budget);
        for (int c = 0; c < budget && got.size() < n; c++) tick();
    endtask

    task automatic do_reset();
        nx_rst = 1'b1;
        tick();
        tick();
        nx_rst = 1'b0;
        tick();
    endtask

    initial begin
        n_chk = 0; n_bad = 0; trunc_cnt = 0; trunc_at = 0; rr_bad = 0; acc3 = 0;
        rst = 1'b1; fifo_ready = 1'b1; fifo_load = '0;
        req_valid = '0; req_last = '0; req_data = '0; acc = '0;
        nx_rst = 1'b1; nx_ready = 1'b1; nx_load = '0;

        tick();
        tick();
        chk("rst_fifo_valid", 32'(fifo_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_grant", 32'(grant_id), 3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_trunc", 32'(trunc_err), 0);
        nx_rst = 1'b0;
        tick();

        // Single 3-beat packet from src0.
        srcq[0].push_back(9'h0A1); srcq[0].push_back(9'h0B2); srcq[0].push_back(9'h1C3);
        run_until(4, 20);
        ex(8'h00); ex(8'hA1); ex(8'hB2); ex(8'hC3);
        chk_seq("pkt3");
        chk("pkt3_grant", 32'(grant_id), 0);
        tick();
        chk("pkt3_idle", 32'(busy), 0);

        // Four contending sources, two 1-beat packets each.
        do_reset();
        for (int i = 0; i < N; i++) begin
            srcq[i].push_back(9'h110 + 9'(i));
            srcq[i].push_back(9'h120 + 9'(i));
        end
        run_until(16, 80);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) begin
                ex(8'(i));
                ex(8'h10 + 8'(r * 16) + 8'(i));
            end
        chk_seq("rr");

        // Free-space gate: 14 free blocks, 16 free grants.
        nx_load = 7'd113;
        srcq[2].push_back(9'h155);
        for (int c = 0; c < 5; c++) tick();
        chk("gate_no_beats", 32'(got.size()), 0);
        chk("gate_idle", 32'(busy), 0);
        nx_load = 7'd111;
        tick();
        tick();
        chk("gate_hdr_valid", 32'(fifo_valid), 1);
        chk("gate_hdr_data", 32'(fifo_data), 2);
        chk("gate_grant", 32'(grant_id), 2);
        run_until(2, 10);
        ex(8'h02); ex(8'h55);
        chk_seq("gate");
        nx_load = '0;

        // Toggling backpressure during a 4-beat packet from src3.
        acc3 = 0;
        srcq[3].push_back(9'h031); srcq[3].push_back(9'h032);
        srcq[3].push_back(9'h033); srcq[3].push_back(9'h134);
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            nx_ready = ~nx_ready;
            tick();
        end
        nx_ready = 1'b1;
        tick();
        ex(8'h03); ex(8'h31); ex(8'h32); ex(8'h33); ex(8'h34);
        chk_seq("bp");
        chk("bp_accepts", 32'(acc3), 4);
        chk("bp_ready_rule", 32'(rr_bad), 0);

        // Runaway packet from src1 is cut after 4 beats.
        trunc_cnt = 0;
        for (int i = 0; i < 6; i++) srcq[1].push_back(9'h041 + 9'(i));
        run_until(8, 40);
        for (int c = 0; c < 3; c++) tick();
        ex(8'h01); ex(8'h41); ex(8'h42); ex(8'h43); ex(8'h44);
        ex(8'h01); ex(8'h45); ex(8'h46);
        chk_seq("trunc");
        chk("trunc_pulses", 32'(trunc_cnt), 1);
        chk("trunc_when", 32'(trunc_at), 5);
        chk("trunc_keeps_grant", 32'(busy), 1);
        chk("trunc_grant", 32'(grant_id), 1);

        // Reset in the middle of a packet.
        do_reset();
        got.delete();
        srcq[0].push_back(9'h061); srcq[0].push_back(9'h062);
        srcq[0].push_back(9'h063); srcq[0].push_back(9'h164);
        srcq[1].push_back(9'h171);
        run_until(2, 20);
        nx_rst = 1'b1;
        nx_ready = 1'b0;
        tick();
        chk("mid_data_valid", 32'(fifo_valid), 1);
        chk("mid_data_beat", 32'(fifo_data), 32'h62);
        tick();
        chk("mrst_fifo_valid", 32'(fifo_valid), 0);
        chk("mrst_req_ready", 32'(req_ready), 0);
        chk("mrst_grant", 32'(grant_id), 3);
        chk("mrst_busy", 32'(busy), 0);
        got.delete();
        nx_rst = 1'b0;
        nx_ready = 1'b1;
        run_until(6, 40);
        ex(8'h00); ex(8'h62); ex(8'h63); ex(8'h64); ex(8'h01); ex(8'h71);
        chk_seq("after_rst");
        chk("ready_rule_all", 32'(rr_bad), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
